pixel_flush_ctrl: RTL and testbench
===================================

Name: pixel_flush_ctrl

Overview:
- Sequences the flush of the 8-pixel plot cache into planar character RAM, one bitplane at a time.
- Drives the per-plane bitplane datapath: a RAM-load strobe (ldram_n), a dump strobe and a plane select.
- Performs a read-modify-write per plane when the cache is partially written, and a write-only pass when it is fully written.
- Sits between the plot unit and the shared RAM port arbiter.

Parameters:
- ADDR_W, 17, RAM byte-address width.
- PLANE_W, 3, plane index width; supports up to 8 bitplanes.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_req  in  1  single-cycle request to flush the cache; sampled in IDLE only.
- bpp_mode  in  2  plane count: 0 = 2 planes, 1 = 4 planes, 2 or 3 = 8 planes; latched at flush start.
- pix_valid  in  8  per-pixel written mask; latched at flush start.
- base_addr  in  ADDR_W  byte address of plane 0 for the tile row; latched at flush start.
- ram_ack  in  1  RAM port completed the current access.
- ram_req  out  1  RAM access request; held high until ram_ack.
- ram_we  out  1  1 = write, 0 = read; valid while ram_req is high.
- ram_addr  out  ADDR_W  address of the current plane.
- plane_sel  out  PLANE_W  current bitplane index to the datapath.
- ldram_n  out  1  active-low, one cycle: datapath captures RAM read data.
- dump  out  1  one cycle: datapath merges draw colour into valid pixels.
- busy  out  1  high from the first cycle after accept until DONE exits.
- done  out  1  one-cycle pulse at flush completion.
- clear_valid  out  1  one-cycle pulse, coincident with done; plot unit clears its valid mask.

Behaviour:
- Reset (async) clears all state:
  - ram_req=0, ram_we=0, ram_addr=0, plane_sel=0, ldram_n=1, dump=0, busy=0, done=0, clear_valid=0.
  - FSM returns to IDLE.
- Reset mid-flush aborts the flush immediately; a partially written plane is not retried.
- States: IDLE, START, READ, LOAD, MERGE, WRITE, NEXT, DONE.
- IDLE:
  - On flush_req, latch bpp_mode, pix_valid and base_addr; plane counter=0; go to START.
  - flush_req in any other state is ignored.
- START:
  - Latched mask == 0: go to DONE. No RAM traffic.
  - Otherwise: go to READ.
- READ:
  - ram_req=1, ram_we=0.
  - When ram_ack=1, go to LOAD. ram_ack may arrive in the same cycle ram_req first rises.
- LOAD: ldram_n=0 for exactly one cycle, then go to MERGE.
- MERGE: dump=1 for exactly one cycle, then go to WRITE.
- WRITE: ram_req=1, ram_we=1; when ram_ack=1, go to NEXT.
- NEXT:
  - If plane == last plane (1, 3 or 7): go to DONE.
  - Otherwise: increment plane, go to READ.
- DONE: done=1 and clear_valid=1 for one cycle, then go to IDLE.
- Address:
  - ram_addr = base + (plane>>1)*16 + (plane&1), in the character-tile planar layout.
  - Computed modulo 2^ADDR_W; wrap-around is silent.
- plane_sel equals the plane counter in every non-IDLE state; it is 0 in IDLE.
- ram_req deasserts in the cycle after the accepted ram_ack. There is no back-to-back request without a state change.
- Minimum latency per plane, with zero-wait ack: READ(1) + LOAD(1) + MERGE(1) + WRITE(1) + NEXT(1) = 5 cycles.

Optional Feature:
- Macro: PIXCACHE_FULL_SKIP_EN.
- When defined and the latched mask == 8'hFF:
  - START goes directly to MERGE, and NEXT returns to MERGE rather than READ.
  - Per plane the sequence is MERGE, WRITE, NEXT; no reads are issued and ldram_n stays high.
- When not defined: every plane always runs the full read-modify-write sequence regardless of the mask.

Test Plan:
- bpp_mode=0, pix_valid=8'h0F, base=0x1000, ack one cycle after each req:
  - Expect read 0x1000, write 0x1000, read 0x1001, write 0x1001.
  - Expect exactly 2 ldram_n and 2 dump pulses, then done and clear_valid together.
- bpp_mode=2, pix_valid=8'h01, base=0x0200:
  - Expect write addresses 0x200, 0x201, 0x210, 0x211, 0x220, 0x221, 0x230, 0x231.
  - plane_sel must match the plane at each write.
- pix_valid=8'h00, flush_req:
  - Expect done 2 cycles after request and ram_req never asserted.
- pix_valid=8'hFF, bpp_mode=1, with PIXCACHE_FULL_SKIP_EN:
  - Expect 4 writes, 0 reads, ldram_n always high.
- Same as previous without the macro: expect 4 reads and 4 writes.
- Assert reset during the second WRITE with ram_req high:
  - Expect all outputs at reset values asynchronously and FSM in IDLE.
  - A new flush_req after reset starts at plane 0.
- Edge cases:
  - flush_req pulsed while busy: ignored.
  - ram_ack stalled 10 cycles: ram_req, ram_we and ram_addr held stable throughout.
  - ram_addr for base=0x1FFF8 with plane 7: wraps to 0x00029.

Source files
------------

// File: rtl/pixel_flush_ctrl.sv
// Plot-cache flush sequencer: walks the bitplanes and drives the RAM port and bitplane datapath.
// Optional build macro PIXCACHE_FULL_SKIP_EN skips the plane read when all 8 pixels are written.
module pixel_flush_ctrl #(
  parameter int ADDR_W  = 17,
  parameter int PLANE_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_req_i,
  input  logic [1:0]        bpp_mode_i,
  input  logic [7:0]        pix_valid_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              ram_ack_i,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [PLANE_W-1:0] plane_sel_o,
  output logic              ldram_n_o,
  output logic              dump_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              clear_valid_o
);

  // state   | meaning
  // IDLE    | waiting for flush_req
  // START   | decide between empty-mask exit, read pass or full-mask skip
  // READ    | RAM read of current plane, waiting for ack
  // LOAD    | datapath captures RAM read data (ldram_n low)
  // MERGE   | datapath merges draw colour into valid pixels (dump high)
  // WRITE   | RAM write of current plane, waiting for ack
  // NEXT    | advance plane or finish
  // DONE    | done / clear_valid pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_LOAD,
    S_MERGE,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [1:0]           bpp_q;
  logic [7:0]           mask_q;
  logic [ADDR_W-1:0]    base_q;
  logic [PLANE_W-1:0]   plane_q;
  logic                 ram_req_q;
  logic                 ram_we_q;
  logic [ADDR_W-1:0]    ram_addr_q;
  logic                 ldram_n_q;
  logic                 dump_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 clear_valid_q;

  logic [PLANE_W-1:0]   plane_d;
  logic [ADDR_W-1:0]    base_d;
  logic [ADDR_W-1:0]    plane_ext;
  logic [ADDR_W-1:0]    addr_d;
  logic [PLANE_W-1:0]   last_plane;
  logic                 full_skip;

`ifdef PIXCACHE_FULL_SKIP_EN
  assign full_skip = (mask_q == 8'hFF);
`else
  assign full_skip = 1'b0;
`endif

  always_comb begin
    case (bpp_q)
      2'd0:    last_plane = PLANE_W'(1);
      2'd1:    last_plane = PLANE_W'(3);
      default: last_plane = PLANE_W'(7);
    endcase
  end

  // Planar tile layout: plane pairs are 16 bytes apart, odd planes sit one byte after even ones.
  always_comb begin
    plane_d = plane_q;
    base_d  = base_q;
    if (state_q == S_IDLE) begin
      plane_d = '0;
      base_d  = base_addr_i;
    end else if (state_q == S_NEXT) begin
      plane_d = plane_q + 1'b1;
    end
    plane_ext = ADDR_W'(plane_d);
    addr_d    = base_d + ((plane_ext >> 1) << 4) + ADDR_W'(plane_d[0]);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      bpp_q         <= '0;
      mask_q        <= '0;
      base_q        <= '0;
      plane_q       <= '0;
      ram_req_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ldram_n_q     <= 1'b1;
      dump_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      clear_valid_q <= 1'b0;
    end else begin
      ldram_n_q     <= 1'b1;
      dump_q        <= 1'b0;
      done_q        <= 1'b0;
      clear_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush_req_i) begin
            bpp_q      <= bpp_mode_i;
            mask_q     <= pix_valid_i;
            base_q     <= base_addr_i;
            plane_q    <= '0;
            ram_addr_q <= addr_d;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (mask_q == 8'h00) begin
            done_q        <= 1'b1;
            clear_valid_q <= 1'b1;
            state_q       <= S_DONE;
          end else if (full_skip) begin
            dump_q  <= 1'b1;
            state_q <= S_MERGE;
          end else begin
            ram_req_q <= 1'b1;
            ram_we_q  <= 1'b0;
            state_q   <= S_READ;
          end
        end
        S_READ: begin
          if (ram_ack_i) begin
            ram_req_q <= 1'b0;
            ldram_n_q <= 1'b0;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          dump_q  <= 1'b1;
          state_q <= S_MERGE;
        end
        S_MERGE: begin
          ram_req_q <= 1'b1;
          ram_we_q  <= 1'b1;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          if (ram_ack_i) begin
            ram_req_q <= 1'b0;
            ram_we_q  <= 1'b0;
            state_q   <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (plane_q == last_plane) begin
            done_q        <= 1'b1;
            clear_valid_q <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            plane_q    <= plane_d;
            ram_addr_q <= addr_d;
            if (full_skip) begin
              dump_q  <= 1'b1;
              state_q <= S_MERGE;
            end else begin
              ram_req_q <= 1'b1;
              ram_we_q  <= 1'b0;
              state_q   <= S_READ;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          plane_q <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_req_o     = ram_req_q;
  assign ram_we_o      = ram_we_q;
  assign ram_addr_o    = ram_addr_q;
  assign plane_sel_o   = plane_q;
  assign ldram_n_o     = ldram_n_q;
  assign dump_o        = dump_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign clear_valid_o = clear_valid_q;

endmodule

// File: tb/tb_pixel_flush_ctrl.sv
// Self-checking bench for pixel_flush_ctrl: table of whole-flush vectors plus directed corner sequences.
module tb_pixel_flush_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_req;
  logic [1:0]  bpp_mode;
  logic [7:0]  pix_valid;
  logic [16:0] base_addr;
  logic        ram_ack;
  logic        ram_req;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [2:0]  plane_sel;
  logic        ldram_n;
  logic        dump;
  logic        busy;
  logic        done;
  logic        clear_valid;

  pixel_flush_ctrl #(.ADDR_W(17), .PLANE_W(3)) dut (
    .clk_i(clk), .reset_i(reset), .flush_req_i(flush_req), .bpp_mode_i(bpp_mode),
    .pix_valid_i(pix_valid), .base_addr_i(base_addr), .ram_ack_i(ram_ack),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .plane_sel_o(plane_sel),
    .ldram_n_o(ldram_n), .dump_o(dump), .busy_o(busy), .done_o(done), .clear_valid_o(clear_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // results of the most recent flush
  int          n_rd, n_wr, n_ld, n_dump, n_done, n_clr, n_coinc, lat, extra, viol, n_tx;
  bit          timed_out;
  logic        tx_we    [64];
  logic [16:0] tx_addr  [64];
  logic [2:0]  tx_plane [64];
  int          wait_cnt;
  logic [16:0] hold_addr;
  logic        hold_we;

  // RAM responder: called once per negedge, acks after `delay` cycles of held request
  task automatic ack_step(input int delay);
    if (ram_req) begin
      if (wait_cnt == 0) begin
        hold_addr = ram_addr;
        hold_we   = ram_we;
      end else if (ram_addr !== hold_addr || ram_we !== hold_we) begin
        viol++;
      end
      if (wait_cnt >= delay) begin
        ram_ack = 1'b1;
        if (n_tx < 64) begin
          tx_we[n_tx]    = ram_we;
          tx_addr[n_tx]  = ram_addr;
          tx_plane[n_tx] = plane_sel;
        end
        n_tx++;
        if (ram_we) n_wr++; else n_rd++;
        wait_cnt = 0;
      end else begin
        ram_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      ram_ack  = 1'b0;
      wait_cnt = 0;
    end
  endtask

  task automatic run_flush(input logic [1:0] bpp, input logic [7:0] mask, input logic [16:0] base,
                           input int delay, input bit poke);
    int cyc;
    bit seen;
    n_rd = 0; n_wr = 0; n_ld = 0; n_dump = 0; n_done = 0; n_clr = 0; n_coinc = 0;
    lat = -1; extra = 0; viol = 0; n_tx = 0; wait_cnt = 0; seen = 0; cyc = 0;
    @(negedge clk);
    flush_req = 1'b1; bpp_mode = bpp; pix_valid = mask; base_addr = base; ram_ack = 1'b0;
    while (!seen && cyc < 600) begin
      @(negedge clk);
      cyc++;
      flush_req = poke && (cyc == 5);
      if (!ldram_n) n_ld++;
      if (dump) n_dump++;
      if (clear_valid) n_clr++;
      if (done) begin
        n_done++;
        seen = 1;
        lat = cyc;
        if (clear_valid) n_coinc++;
      end
      ack_step(delay);
    end
    timed_out = !seen;
    ram_ack = 1'b0;
    flush_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy || ram_req) extra++;
      if (done) n_done++;
    end
  endtask

  typedef struct {
    logic [1:0]  bpp;
    logic [7:0]  mask;
    logic [16:0] base;
    int          delay;
    bit          poke;
    int          e_rd, e_wr, e_ld, e_dump;
    logic [16:0] e_first;
    int          e_lat;
  } vec_t;

  vec_t vecs [7];
  logic [16:0] exp_wa [8];
  int k;
  bit hit, prev_wr;
  int wr_seen;

  initial begin
    vecs[0] = '{2'd0, 8'h0F, 17'h01000, 1,  1'b0, 2, 2, 2, 2, 17'h01000, -1};
    vecs[1] = '{2'd2, 8'h01, 17'h00200, 0,  1'b0, 8, 8, 8, 8, 17'h00200, -1};
    vecs[2] = '{2'd1, 8'h00, 17'h00300, 0,  1'b0, 0, 0, 0, 0, 17'h00000,  2};
`ifdef PIXCACHE_FULL_SKIP_EN
    vecs[3] = '{2'd1, 8'hFF, 17'h00400, 0,  1'b0, 0, 4, 0, 4, 17'h00400, -1};
`else
    vecs[3] = '{2'd1, 8'hFF, 17'h00400, 0,  1'b0, 4, 4, 4, 4, 17'h00400, -1};
`endif
    vecs[4] = '{2'd0, 8'h0F, 17'h01000, 10, 1'b1, 2, 2, 2, 2, 17'h01000, -1};
    vecs[5] = '{2'd3, 8'h80, 17'h1FFF8, 2,  1'b0, 8, 8, 8, 8, 17'h1FFF8, -1};
    vecs[6] = '{2'd1, 8'h3C, 17'h00000, 0,  1'b1, 4, 4, 4, 4, 17'h00000, -1};
    exp_wa = '{17'h200, 17'h201, 17'h210, 17'h211, 17'h220, 17'h221, 17'h230, 17'h231};

    reset = 1'b1; flush_req = 1'b0; bpp_mode = 2'd0; pix_valid = 8'h00;
    base_addr = 17'h0; ram_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, ram_req}, 32'd0);
    check("rst_ldram_n", {31'd0, ldram_n}, 32'd1);
    check("rst_busy_done", {29'd0, busy, done, clear_valid}, 32'd0);
    check("rst_addr_plane", {12'd0, ram_addr, plane_sel}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_flush(vecs[i].bpp, vecs[i].mask, vecs[i].base, vecs[i].delay, vecs[i].poke);
      check($sformatf("v%0d_timeout", i), {31'd0, timed_out}, 32'd0);
      check($sformatf("v%0d_reads", i), n_rd, vecs[i].e_rd);
      check($sformatf("v%0d_writes", i), n_wr, vecs[i].e_wr);
      check($sformatf("v%0d_ldram", i), n_ld, vecs[i].e_ld);
      check($sformatf("v%0d_dump", i), n_dump, vecs[i].e_dump);
      check($sformatf("v%0d_done", i), n_done, 1);
      check($sformatf("v%0d_clr_with_done", i), n_coinc, 1);
      check($sformatf("v%0d_clr", i), n_clr, 1);
      check($sformatf("v%0d_idle_after", i), extra, 0);
      check($sformatf("v%0d_stall_stable", i), viol, 0);
      if (vecs[i].e_rd + vecs[i].e_wr > 0)
        check($sformatf("v%0d_first_addr", i), {15'd0, tx_addr[0]}, {15'd0, vecs[i].e_first});
      if (vecs[i].e_lat >= 0)
        check($sformatf("v%0d_done_latency", i), lat, vecs[i].e_lat);
    end

    // read/write ordering and addresses for the 2-plane case
    run_flush(2'd0, 8'h0F, 17'h01000, 1, 1'b0);
    check("seq_ntx", n_tx, 4);
    check("seq0", {14'd0, tx_we[0], tx_addr[0]}, {14'd0, 1'b0, 17'h01000});
    check("seq1", {14'd0, tx_we[1], tx_addr[1]}, {14'd0, 1'b1, 17'h01000});
    check("seq2", {14'd0, tx_we[2], tx_addr[2]}, {14'd0, 1'b0, 17'h01001});
    check("seq3", {14'd0, tx_we[3], tx_addr[3]}, {14'd0, 1'b1, 17'h01001});

    // 8-plane write addresses and plane_sel at each write
    run_flush(2'd2, 8'h01, 17'h00200, 0, 1'b0);
    k = 0;
    for (int i = 0; i < n_tx && i < 64; i++) begin
      if (tx_we[i] && k < 8) begin
        check($sformatf("wa%0d_addr", k), {15'd0, tx_addr[i]}, {15'd0, exp_wa[k]});
        check($sformatf("wa%0d_plane", k), {29'd0, tx_plane[i]}, k);
        k++;
      end
    end
    check("wa_count", k, 8);

    // address wrap at plane 7
    run_flush(2'd2, 8'h01, 17'h1FFF8, 0, 1'b0);
    check("wrap_addr", {15'd0, tx_addr[15]}, 32'h00029);
    check("wrap_plane", {29'd0, tx_plane[15]}, 32'd7);

    // reset during the second WRITE with ram_req held
    @(negedge clk);
    flush_req = 1'b1; bpp_mode = 2'd0; pix_valid = 8'h0F; base_addr = 17'h01000; ram_ack = 1'b0;
    n_tx = 0; n_rd = 0; n_wr = 0; viol = 0; wait_cnt = 0;
    hit = 0; prev_wr = 0; wr_seen = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      flush_req = 1'b0;
      if (ram_req && ram_we && !prev_wr) wr_seen++;
      prev_wr = ram_req && ram_we;
      if (wr_seen == 2) begin
        hit = 1;
        ram_ack = 1'b0;
      end else begin
        ack_step(2);
      end
    end
    check("rst_mid_reached", {31'd0, hit}, 32'd1);
    check("rst_mid_pre_req", {30'd0, ram_req, ram_we}, 32'd3);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_req_we", {30'd0, ram_req, ram_we}, 32'd0);
    check("rst_mid_addr", {15'd0, ram_addr}, 32'd0);
    check("rst_mid_plane", {29'd0, plane_sel}, 32'd0);
    check("rst_mid_strobes", {28'd0, ldram_n, dump, done, clear_valid}, 32'd8);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    #1 reset = 1'b0;

    run_flush(2'd0, 8'h0F, 17'h01000, 0, 1'b0);
    check("post_rst_timeout", {31'd0, timed_out}, 32'd0);
    check("post_rst_first", {14'd0, tx_we[0], tx_addr[0]}, {14'd0, 1'b0, 17'h01000});
    check("post_rst_plane0", {29'd0, tx_plane[0]}, 32'd0);
    check("post_rst_writes", n_wr, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
